dmem_arbiter: RTL and testbench



---
 rtl/dmem_pkg.sv | 6 +
 rtl/dmem_ram.sv | 21 ++
 rtl/dmem_arbiter.sv | 91 +++++++++
 tb/tb_dmem_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and requester ids for the data-memory arbiter.
package dmem_pkg;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 64;
    typedef enum logic {REQ_CPU = 1'b0, REQ_LD = 1'b1} req_id_e;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port array, synchronous write and read-before-write synchronous read.
module dmem_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares dmem_ram between core and loader, one access per cycle.
// DMEM_ARB_RR_EN selects round-robin on conflict; otherwise the core has fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              conflict
);
    req_id_e           last_q, last_d;
    logic              rv_cpu_q, rv_cpu_d, rv_ld_q, rv_ld_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, ld_rdata_q, ld_rdata_d;
    logic [DATA_W-1:0] ram_rdata, ram_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en, ram_we, ld_wins;

    dmem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= REQ_LD;
            rv_cpu_q    <= 1'b0;
            rv_ld_q     <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            last_q      <= last_d;
            rv_cpu_q    <= rv_cpu_d;
            rv_ld_q     <= rv_ld_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    always_comb begin
        conflict = cpu_req && ld_req;
`ifdef DMEM_ARB_RR_EN
        ld_wins = conflict && (last_q == REQ_CPU);
`else
        ld_wins = 1'b0;
`endif
        cpu_gnt = cpu_req && !ld_wins;
        ld_gnt  = ld_req && !cpu_gnt;
        last_d  = cpu_gnt ? REQ_CPU : ld_gnt ? REQ_LD : last_q;
    end

    // Accesses presented while rst is high never reach the array.
    always_comb begin
        ram_en    = (cpu_gnt || ld_gnt) && !rst;
        ram_we    = cpu_gnt ? cpu_we : ld_we;
        ram_addr  = cpu_gnt ? cpu_addr : ld_addr;
        ram_wdata = cpu_gnt ? cpu_wdata : ld_wdata;
        rv_cpu_d  = cpu_gnt && !cpu_we;
        rv_ld_d   = ld_gnt && !ld_we;
    end

    // Each requester sees fresh RAM data on its rvalid cycle and holds it afterwards.
    always_comb begin
        cpu_rdata_d = rv_cpu_q ? ram_rdata : cpu_rdata_q;
        ld_rdata_d  = rv_ld_q ? ram_rdata : ld_rdata_q;
        cpu_rdata   = cpu_rdata_d;
        ld_rdata    = ld_rdata_d;
        cpu_rvalid  = rv_cpu_q && !rst;
        ld_rvalid   = rv_ld_q && !rst;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, reset corner cases and random traffic against a memory model.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [63:0] D1   = 64'hDEADBEEF_00000001;
    localparam logic [63:0] FF   = '1;
    localparam logic [63:0] ONE  = 64'h1;
    localparam logic [63:0] INIT = 64'hC0DE0000_00000000;

    logic        clk, rst;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [5:0]  cpu_addr;
    logic [63:0] cpu_wdata, cpu_rdata;
    logic        ld_req, ld_we, ld_gnt, ld_rvalid, conflict;
    logic [5:0]  ld_addr;
    logic [63:0] ld_wdata, ld_rdata;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .conflict(conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] mem_m [64];
    bit          last_m, rvc_m, rvl_m, cg_m, lg_m;
    logic [63:0] crd_m, lrd_m;

    typedef struct {
        bit r, creq, cwe; logic [5:0] caddr; logic [63:0] cwd;
        bit lreq, lwe; logic [5:0] laddr; logic [63:0] lwd;
        bit cg, lg, conf, rvc, rvl; logic [63:0] crd, lrd;
    } vec_t;
    vec_t tv [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one cycle's inputs, then checks the DUT against the model at the falling edge.
    task automatic apply(input bit r, input bit creq, input bit cwe, input logic [5:0] caddr,
                         input logic [63:0] cwd, input bit lreq, input bit lwe,
                         input logic [5:0] laddr, input logic [63:0] lwd);
        rst = r; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        ld_req = lreq; ld_we = lwe; ld_addr = laddr; ld_wdata = lwd;
        #4;
        cg_m = creq && !(lreq && RR && !last_m);
        lg_m = lreq && !cg_m;
        chk("cpu_gnt", cpu_gnt, cg_m);
        chk("ld_gnt", ld_gnt, lg_m);
        chk("conflict", conflict, creq && lreq);
        chk("cpu_rvalid", cpu_rvalid, rvc_m && !r);
        chk("ld_rvalid", ld_rvalid, rvl_m && !r);
        chk("cpu_rdata", cpu_rdata, crd_m);
        chk("ld_rdata", ld_rdata, lrd_m);
    endtask

    // Advances the model across the rising edge using the inputs left by apply.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            rvc_m = 0; rvl_m = 0; crd_m = '0; lrd_m = '0; last_m = 1;
        end else begin
            rvc_m = cg_m && !cpu_we;
            rvl_m = lg_m && !ld_we;
            if (cg_m) begin
                if (cpu_we) mem_m[cpu_addr] = cpu_wdata; else crd_m = mem_m[cpu_addr];
                last_m = 0;
            end
            if (lg_m) begin
                if (ld_we) mem_m[ld_addr] = ld_wdata; else lrd_m = mem_m[ld_addr];
                last_m = 1;
            end
        end
        #1;
    endtask

    task automatic cyc(input bit r, input bit creq, input bit cwe, input logic [5:0] caddr,
                       input logic [63:0] cwd, input bit lreq, input bit lwe,
                       input logic [5:0] laddr, input logic [63:0] lwd);
        apply(r, creq, cwe, caddr, cwd, lreq, lwe, laddr, lwd);
        step();
    endtask

    initial begin
        bit pc, pl, r, creq, cwe, lreq, lwe;
        logic [5:0] caddr, laddr;
        logic [63:0] cwd, lwd;
        tv[0]  = '{0, 1,1, 5,D1, 0,0, 0,0,   1,0,0, 0,0, 0,0};
        tv[1]  = '{0, 1,0, 5,0,  0,0, 0,0,   1,0,0, 0,0, 0,0};
        tv[2]  = '{0, 0,0, 0,0,  1,1,63,FF,  0,1,0, 1,0, D1,0};
        tv[3]  = '{0, 0,0, 0,0,  1,1, 0,ONE, 0,1,0, 0,0, D1,0};
        tv[4]  = '{0, 1,0,63,0,  0,0, 0,0,   1,0,0, 0,0, D1,0};
        tv[5]  = '{0, 1,0, 0,0,  0,0, 0,0,   1,0,0, 1,0, FF,0};
        tv[6]  = '{1, 0,0, 0,0,  0,0, 0,0,   0,0,0, 0,0, ONE,0};
        tv[7]  = '{0, 1,0, 5,0,  1,0,63,0,   1,0,1, 0,0, 0,0};
        tv[8]  = '{0, 1,0, 5,0,  1,0,63,0,   !RR,RR,1, 1,0, D1,0};
        tv[9]  = '{0, 1,0, 5,0,  1,0,63,0,   1,0,1, !RR,RR, D1,(RR ? FF : 64'h0)};
        tv[10] = '{0, 1,0, 5,0,  1,0,63,0,   !RR,RR,1, 1,0, D1,(RR ? FF : 64'h0)};
        tv[11] = '{0, 0,0, 0,0,  1,0,63,0,   0,1,0, !RR,RR, D1,(RR ? FF : 64'h0)};
        tv[12] = '{0, 0,0, 0,0,  0,0, 0,0,   0,0,0, 0,1, D1,FF};

        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rvc_m = 0; rvl_m = 0; crd_m = '0; lrd_m = '0; last_m = 1;
        for (int i = 0; i < 64; i++) cyc(0, 0,0,0,0, 1,1,6'(i), INIT | 64'(i));
        cyc(1, 0,0,0,0, 0,0,0,0);

        for (int i = 0; i < 13; i++) begin
            apply(tv[i].r, tv[i].creq, tv[i].cwe, tv[i].caddr, tv[i].cwd,
                  tv[i].lreq, tv[i].lwe, tv[i].laddr, tv[i].lwd);
            chk($sformatf("tv%0d_cpu_gnt", i), cpu_gnt, tv[i].cg);
            chk($sformatf("tv%0d_ld_gnt", i), ld_gnt, tv[i].lg);
            chk($sformatf("tv%0d_conflict", i), conflict, tv[i].conf);
            chk($sformatf("tv%0d_cpu_rvalid", i), cpu_rvalid, tv[i].rvc);
            chk($sformatf("tv%0d_ld_rvalid", i), ld_rvalid, tv[i].rvl);
            chk($sformatf("tv%0d_cpu_rdata", i), cpu_rdata, tv[i].crd);
            chk($sformatf("tv%0d_ld_rdata", i), ld_rdata, tv[i].lrd);
            step();
        end

        cyc(0, 1,0,5,0, 0,0,0,0);
        apply(1, 0,0,0,0, 0,0,0,0);
        chk("rst_pend_rvalid_n1", cpu_rvalid, 0);
        step();
        apply(0, 0,0,0,0, 0,0,0,0);
        chk("rst_pend_rvalid_n2", cpu_rvalid, 0);
        chk("rst_pend_rdata", cpu_rdata, 0);
        step();

        cyc(1, 1,1,9,64'h1234, 0,0,0,0);
        cyc(0, 1,0,9,0, 0,0,0,0);
        apply(0, 0,0,0,0, 0,0,0,0);
        chk("rst_write_dropped", cpu_rdata, INIT | 64'd9);
        step();

        pc = 0; pl = 0;
        creq = 0; cwe = 0; caddr = '0; cwd = '0; lreq = 0; lwe = 0; laddr = '0; lwd = '0;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            if (!pc) begin
                creq = ($urandom_range(0, 3) != 0); cwe = 1'($urandom);
                caddr = 6'($urandom_range(0, 7)); cwd = {$urandom, $urandom};
            end
            if (!pl) begin
                lreq = ($urandom_range(0, 3) != 0); lwe = 1'($urandom);
                laddr = 6'($urandom_range(0, 7)); lwd = {$urandom, $urandom};
            end
            apply(r, creq, cwe, caddr, cwd, lreq, lwe, laddr, lwd);
            pc = creq && !cg_m;
            pl = lreq && !lg_m;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
